// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle main controller.
// State, opcode, ALUOp, mux-select, ImmSrc and ALUControl codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_FN  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: controller <-> datapath bundle.
// master = controller (decode inputs in, control lines out);
// slave = datapath. MemReady exists only with MEM_WAIT_EN.
interface mc_main_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
`ifdef MEM_WAIT_EN
   logic       MemReady;
`endif
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       InstrDone;
   logic       IllegalOp;

   modport master (
      input  op, funct3, funct7b5, Zero,
`ifdef MEM_WAIT_EN
      input  MemReady,
`endif
      output PCWrite, AdrSrc, MemWrite, IRWrite,
      output ResultSrc, ALUSrcA, ALUSrcB,
      output RegWrite, ImmSrc, ALUControl,
      output InstrDone, IllegalOp
   );

   modport slave (
      output op, funct3, funct7b5, Zero,
`ifdef MEM_WAIT_EN
      output MemReady,
`endif
      input  PCWrite, AdrSrc, MemWrite, IRWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB,
      input  RegWrite, ImmSrc, ALUControl,
      input  InstrDone, IllegalOp
   );
endinterface

// File: rtl/mc_alu_ctrl.sv
// mc_alu_ctrl: ALUOp/funct3/funct7b5/op[5] -> ALUControl.
// Ports: aluop, funct3, funct7b5, opb5 in; alucontrol out.
module mc_alu_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       opb5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALUC_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALUC_SUB;
         ALUOP_FN: begin
            case (funct3)
               // funct7b5 is an imm bit for I-type, so op[5] gates sub
               3'b000:
                  if (funct7b5 & opb5)
                     alucontrol = ALUC_SUB;
               3'b010:  alucontrol = ALUC_SLT;
               3'b110:  alucontrol = ALUC_OR;
               3'b111:  alucontrol = ALUC_AND;
               default: alucontrol = ALUC_ADD;
            endcase
         end
         default: alucontrol = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle Moore main controller (RV32I subset).
// Ports: clk, rst_n (sync, active-low), bus (mc_main_ctrl_if.master).
// Option MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall on MemReady.
module mc_main_ctrl
   import mc_ctrl_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   mc_main_ctrl_if.master bus
);

   state_t     state;
   logic       rdy;
   logic       pc_upd, branch;
   logic       mw, irw, rw, done, ill;
   logic [1:0] aluop;

`ifdef MEM_WAIT_EN
   assign rdy = bus.MemReady;
`else
   assign rdy = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:
               if (rdy) state <= S_DECODE;
            S_DECODE: begin
               case (bus.op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_R:         state <= S_EXECR;
                  OP_I:         state <= S_EXECI;
                  OP_BEQ:       state <= S_BEQ;
                  OP_JAL:       state <= S_JAL;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEMADR:
               state <= (bus.op == OP_SW) ?
                        S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:
               if (rdy) state <= S_MEMWB;
            S_MEMWRITE:
               if (rdy) state <= S_FETCH;
            S_EXECR, S_EXECI, S_JAL:
               state <= S_ALUWB;
            default:
               state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_upd        = 1'b0;
      branch        = 1'b0;
      mw            = 1'b0;
      irw           = 1'b0;
      rw            = 1'b0;
      done          = 1'b0;
      ill           = 1'b0;
      aluop         = ALUOP_ADD;
      bus.AdrSrc    = 1'b0;
      bus.ResultSrc = RES_ALUOUT;
      bus.ALUSrcA   = SRCA_PC;
      bus.ALUSrcB   = SRCB_RS2;
      case (state)
         S_FETCH: begin
            irw           = rdy;
            pc_upd        = rdy;
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ResultSrc = RES_ALURES;
         end
         S_DECODE: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW, OP_R,
               OP_I, OP_BEQ, OP_JAL: ill = 1'b0;
               default:              ill = 1'b1;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            bus.ResultSrc = RES_DATA;
            rw            = 1'b1;
            done          = 1'b1;
         end
         S_MEMWRITE: begin
            bus.AdrSrc = 1'b1;
            mw         = 1'b1;
            done       = rdy;
         end
         S_EXECR: begin
            bus.ALUSrcA = SRCA_RS1;
            aluop       = ALUOP_FN;
         end
         S_EXECI: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
            aluop       = ALUOP_FN;
         end
         S_ALUWB: begin
            rw   = 1'b1;
            done = 1'b1;
         end
         S_BEQ: begin
            bus.ALUSrcA = SRCA_RS1;
            aluop       = ALUOP_SUB;
            branch      = 1'b1;
            done        = 1'b1;
         end
         S_JAL: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_FOUR;
            pc_upd      = 1'b1;
         end
         default: begin
            pc_upd = 1'b0;
         end
      endcase
   end

   // enables are gated so nothing writes while reset is held
   assign bus.PCWrite   = rst_n &
                          (pc_upd | (branch & bus.Zero));
   assign bus.MemWrite  = rst_n & mw;
   assign bus.IRWrite   = rst_n & irw;
   assign bus.RegWrite  = rst_n & rw;
   assign bus.InstrDone = rst_n & done;
   assign bus.IllegalOp = rst_n & ill;

   always_comb begin
      case (bus.op)
         OP_SW:   bus.ImmSrc = IMM_S;
         OP_BEQ:  bus.ImmSrc = IMM_B;
         OP_JAL:  bus.ImmSrc = IMM_J;
         default: bus.ImmSrc = IMM_I;
      endcase
   end

   mc_alu_ctrl u_alu_ctrl (
      .aluop      (aluop),
      .funct3     (bus.funct3),
      .funct7b5   (bus.funct7b5),
      .opb5       (bus.op[5]),
      .alucontrol (bus.ALUControl)
   );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: scoreboard bench for mc_main_ctrl.
// Directed per-cycle expectations queued, checked on negedge.
module tb_mc_main_ctrl;

   logic clk;
   logic rst_n;
   int   ncmp;
   int   nfail;

   mc_main_ctrl_if bus ();

   mc_main_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [17:0] v;
   } exp_t;

   exp_t q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [17:0] pk(
      input logic pcw, input logic adr,
      input logic mw, input logic irw,
      input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic rw,
      input logic [1:0] imm, input logic [2:0] alc,
      input logic done, input logic ill);
      return {pcw, adr, mw, irw, rs, sa, sb,
              rw, imm, alc, done, ill};
   endfunction

   // hand-written expectation per controller state
   function automatic logic [17:0] e_f(input logic [1:0] im);
      return pk(1,0,0,1,2'b10,2'b00,2'b10,0,im,3'b000,0,0);
   endfunction
   function automatic logic [17:0] e_fr(input logic [1:0] im);
      return pk(0,0,0,0,2'b10,2'b00,2'b10,0,im,3'b000,0,0);
   endfunction
   function automatic logic [17:0] e_d(input logic [1:0] im);
      return pk(0,0,0,0,2'b00,2'b01,2'b01,0,im,3'b000,0,0);
   endfunction
   function automatic logic [17:0] e_dill();
      return pk(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000,0,1);
   endfunction
   function automatic logic [17:0] e_ma(input logic [1:0] im);
      return pk(0,0,0,0,2'b00,2'b10,2'b01,0,im,3'b000,0,0);
   endfunction
   function automatic logic [17:0] e_mr();
      return pk(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,3'b000,0,0);
   endfunction
   function automatic logic [17:0] e_mwb();
      return pk(0,0,0,0,2'b01,2'b00,2'b00,1,2'b00,3'b000,1,0);
   endfunction
   function automatic logic [17:0] e_mw(input logic dn);
      return pk(0,1,1,0,2'b00,2'b00,2'b00,0,2'b01,3'b000,dn,0);
   endfunction
   function automatic logic [17:0] e_xr(input logic [2:0] a);
      return pk(0,0,0,0,2'b00,2'b10,2'b00,0,2'b00,a,0,0);
   endfunction
   function automatic logic [17:0] e_xi(input logic [2:0] a);
      return pk(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,a,0,0);
   endfunction
   function automatic logic [17:0] e_wb(input logic [1:0] im);
      return pk(0,0,0,0,2'b00,2'b00,2'b00,1,im,3'b000,1,0);
   endfunction
   function automatic logic [17:0] e_bq(input logic z);
      return pk(z,0,0,0,2'b00,2'b10,2'b00,0,2'b10,3'b001,1,0);
   endfunction
   function automatic logic [17:0] e_j();
      return pk(1,0,0,0,2'b00,2'b01,2'b10,0,2'b11,3'b000,0,0);
   endfunction

   function automatic logic [17:0] act();
      return {bus.PCWrite, bus.AdrSrc, bus.MemWrite,
              bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
              bus.ALUSrcB, bus.RegWrite, bus.ImmSrc,
              bus.ALUControl, bus.InstrDone, bus.IllegalOp};
   endfunction

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         logic [17:0] a;
         e = q.pop_front();
         a = act();
         ncmp++;
         if (a !== e.v) begin
            nfail++;
            $display("FAIL %s: got %05h want %05h",
                     e.name, a, e.v);
         end
      end
   end

   task automatic step(input string n, input logic [17:0] v);
      exp_t e;
      e.name = n;
      e.v    = v;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input logic [6:0] o,
                          input logic [2:0] f3,
                          input logic f7, input logic z);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.Zero     = z;
   endtask

   initial begin
      ncmp  = 0;
      nfail = 0;
      rst_n = 1'b0;
      set_ins(7'b0110011, 3'b000, 1'b1, 1'b0);
`ifdef MEM_WAIT_EN
      bus.MemReady = 1'b1;
`endif
      @(posedge clk);
      #1;
      step("rst_hold1", e_fr(2'b00));
      rst_n = 1'b1;
      // sub: reset lands while in EXECR
      step("sub_f", e_f(2'b00));
      step("sub_d", e_d(2'b00));
      rst_n = 1'b0;
      step("rst_execr", e_xr(3'b001));
      step("rst_fetch", e_fr(2'b00));
      rst_n = 1'b1;
      step("post_rst_f", e_f(2'b00));
      step("sub_d2", e_d(2'b00));
      step("sub_x", e_xr(3'b001));
      step("sub_wb", e_wb(2'b00));
      // add
      set_ins(7'b0110011, 3'b000, 1'b0, 1'b0);
      step("add_f", e_f(2'b00));
      step("add_d", e_d(2'b00));
      step("add_x", e_xr(3'b000));
      step("add_wb", e_wb(2'b00));
      // slt / and / unsupported funct3
      set_ins(7'b0110011, 3'b010, 1'b0, 1'b0);
      step("slt_f", e_f(2'b00));
      step("slt_d", e_d(2'b00));
      step("slt_x", e_xr(3'b101));
      step("slt_wb", e_wb(2'b00));
      set_ins(7'b0110011, 3'b111, 1'b0, 1'b0);
      step("and_f", e_f(2'b00));
      step("and_d", e_d(2'b00));
      step("and_x", e_xr(3'b010));
      step("and_wb", e_wb(2'b00));
      set_ins(7'b0110011, 3'b001, 1'b1, 1'b0);
      step("f001_f", e_f(2'b00));
      step("f001_d", e_d(2'b00));
      step("f001_x", e_xr(3'b000));
      step("f001_wb", e_wb(2'b00));
      // addi with imm bit 30 set still adds; ori
      set_ins(7'b0010011, 3'b000, 1'b1, 1'b0);
      step("addi_f", e_f(2'b00));
      step("addi_d", e_d(2'b00));
      step("addi_x", e_xi(3'b000));
      step("addi_wb", e_wb(2'b00));
      set_ins(7'b0010011, 3'b110, 1'b0, 1'b0);
      step("ori_f", e_f(2'b00));
      step("ori_d", e_d(2'b00));
      step("ori_x", e_xi(3'b011));
      step("ori_wb", e_wb(2'b00));
      // lw
      set_ins(7'b0000011, 3'b010, 1'b0, 1'b0);
      step("lw_f", e_f(2'b00));
      step("lw_d", e_d(2'b00));
      step("lw_ma", e_ma(2'b00));
      step("lw_mr", e_mr());
      step("lw_wb", e_mwb());
      // sw
      set_ins(7'b0100011, 3'b010, 1'b0, 1'b0);
      step("sw_f", e_f(2'b01));
      step("sw_d", e_d(2'b01));
      step("sw_ma", e_ma(2'b01));
      step("sw_mw", e_mw(1'b1));
      // beq taken / not taken
      set_ins(7'b1100011, 3'b000, 1'b0, 1'b1);
      step("beqt_f", e_f(2'b10));
      step("beqt_d", e_d(2'b10));
      step("beqt_b", e_bq(1'b1));
      set_ins(7'b1100011, 3'b000, 1'b0, 1'b0);
      step("beqn_f", e_f(2'b10));
      step("beqn_d", e_d(2'b10));
      step("beqn_b", e_bq(1'b0));
      // jal
      set_ins(7'b1101111, 3'b000, 1'b0, 1'b0);
      step("jal_f", e_f(2'b11));
      step("jal_d", e_d(2'b11));
      step("jal_j", e_j());
      step("jal_wb", e_wb(2'b11));
      // illegal opcode
      set_ins(7'b1111111, 3'b000, 1'b0, 1'b0);
      step("ill_f", e_f(2'b00));
      step("ill_d", e_dill());
      step("ill_f2", e_f(2'b00));
`ifdef MEM_WAIT_EN
      // sw with three not-ready cycles in MEMWRITE
      set_ins(7'b0100011, 3'b010, 1'b0, 1'b0);
      step("wsw_d", e_d(2'b01));
      step("wsw_ma", e_ma(2'b01));
      bus.MemReady = 1'b0;
      step("wsw_w1", e_mw(1'b0));
      step("wsw_w2", e_mw(1'b0));
      step("wsw_w3", e_mw(1'b0));
      bus.MemReady = 1'b1;
      step("wsw_w4", e_mw(1'b1));
      bus.MemReady = 1'b0;
      step("wsw_fw", e_fr(2'b01));
      bus.MemReady = 1'b1;
      step("wsw_f", e_f(2'b01));
`else
      step("ill_d2", e_dill());
      step("end_f", e_f(2'b00));
`endif
      for (int i = 0; i < 10 && q.size() != 0; i++)
         @(negedge clk);
      #1;
      if (q.size() != 0) begin
         ncmp++;
         nfail++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle main controller for the RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Moore FSM sequences fetch/decode/execute/memory/writeback over the shared ALU, memory port and register file.
- Drives datapath select and enable lines, and ALUOp into the ALU-control decode sub-module.
- Outputs ALUControl, ImmSrc and instruction-retire/illegal pulses.

Parameters:
- none (opcode and state encodings are fixed constants in the shared package)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/oldPC register load
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  add 000, sub 001, and 010, or 011, slt 101
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- Reset: one clock; reset is synchronous and active-low. With rst_n=0 at a clk edge, state <= FETCH. While rst_n=0, all enables (PCWrite, MemWrite, IRWrite, RegWrite, InstrDone, IllegalOp) are forced 0. Selects show FETCH decode.
- Reset mid-instruction: the instruction is abandoned, with no partial writes after that edge.
- State register is 4 bits. Outputs are combinational from state, plus op/funct/Zero where noted.
- Default for all outputs is 0 unless listed.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, InstrDone=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero).
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw (0000011) / sw (0100011) -> MEMADR; R (0110011) -> EXECR; I (0010011) -> EXECI; beq (1100011) -> BEQ; jal (1101111) -> JAL; any other opcode -> FETCH with IllegalOp=1 and no write enables.
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR / EXECI -> ALUWB -> FETCH.
  - JAL -> ALUWB.
  - BEQ -> FETCH.
- Unreachable state encodings -> FETCH next cycle, with all enables 0.
- Latency (cycles): lw 5; sw 4; R 4; I 4; jal 4; beq 3; illegal 2.
- ImmSrc is combinational from op: lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- ALUControl from sub-module:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, funct3 000: sub if funct7b5 & op[5], else add.
  - funct3 010 -> slt; 110 -> or; 111 -> and.
  - Other funct3 -> 000 (no X).

Optional Feature:
- MEM_WAIT_EN defined:
  - Adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - IRWrite and PCUpdate assert only in the FETCH cycle where MemReady=1.
  - MemWrite holds high until MemReady=1. InstrDone in MEMWRITE pulses on that cycle only.
- MEM_WAIT_EN undefined: no MemReady port; every state lasts exactly one cycle.

Decomposition:
- Package mc_ctrl_pkg:
  - State enum (FETCH=0 … JAL=10, 4-bit).
  - Opcode constants.
  - ALUOp, ResultSrc, ALUSrcA/B, ImmSrc and ALUControl code constants.
- Sub-module mc_alu_ctrl: combinational ALUOp/funct3/funct7b5/opb5 -> ALUControl.
- FSM, output decode and ImmSrc decode stay in mc_main_ctrl.

Test Plan:
- Reset: rst_n=0 for 2 cycles while in EXECR -> state FETCH, RegWrite/MemWrite/PCWrite=0 during reset. First cycle after release: IRWrite=1, PCWrite=1.
- lw (op=0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5; InstrDone pulses once; ImmSrc=00.
- sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECR, RegWrite in cycle 4. Same instruction with funct7b5=0 -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in cycle 3. With Zero=0 -> PCWrite=0. ALUControl=001 in BEQ and ImmSrc=10 in both cases.
- Illegal op=1111111 -> FETCH, DECODE, then IllegalOp=1 and FETCH. No RegWrite or MemWrite at any point.
- MEM_WAIT_EN build: sw with MemReady low for 3 cycles -> MemWrite high 4 cycles, single InstrDone pulse, then FETCH.
